// File: rtl/simpleuart_pkg.sv
// simpleuart shared constants: RX state encoding, TX frame lengths,
// divider reset value.
package simpleuart_pkg;

    typedef enum logic [3:0] {
        RX_IDLE  = 4'd0,
        RX_START = 4'd1,
        RX_DATA0 = 4'd2,
        RX_DATA1 = 4'd3,
        RX_DATA2 = 4'd4,
        RX_DATA3 = 4'd5,
        RX_DATA4 = 4'd6,
        RX_DATA5 = 4'd7,
        RX_DATA6 = 4'd8,
        RX_DATA7 = 4'd9,
        RX_STOP  = 4'd10
    } rx_state_t;

    localparam logic [3:0]  TX_FRAME_BITS = 4'd10;
    localparam logic [3:0]  TX_DUMMY_BITS = 4'd15;
    localparam logic [31:0] DIV_RESET     = 32'd1;

endpackage

// File: rtl/simpleuart.sv
// simpleuart: memory-mapped 8N1 UART with programmable divider,
// single-byte receive buffer and write-stalling transmitter.
module simpleuart
    import simpleuart_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    output logic        ser_tx,
    input  logic        ser_rx,
    input  logic [3:0]  reg_div_we,
    input  logic [31:0] reg_div_di,
    output logic [31:0] reg_div_do,
    input  logic        reg_dat_we,
    input  logic        reg_dat_re,
    input  logic [31:0] reg_dat_di,
    output logic [31:0] reg_dat_do,
    output logic        reg_dat_wait
);

    logic [31:0] cfg_divider;

    rx_state_t   recv_state;
    logic [31:0] recv_divcnt;
    logic [7:0]  recv_pattern;
    logic [7:0]  recv_buf_data;
    logic        recv_buf_valid;

    logic [9:0]  send_pattern;
    logic [3:0]  send_bitcnt;
    logic [31:0] send_divcnt;
    logic        send_dummy;

    logic        unused_di;

    assign unused_di    = ^reg_dat_di[31:8];
    assign reg_div_do   = cfg_divider;
    assign reg_dat_do   = recv_buf_valid ? {24'h0, recv_buf_data} : 32'hFFFF_FFFF;
    assign reg_dat_wait = reg_dat_we && (send_bitcnt != 4'd0 || send_dummy);
    assign ser_tx       = send_pattern[0];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cfg_divider <= DIV_RESET;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (reg_div_we[i])
                    cfg_divider[8*i +: 8] <= reg_div_di[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            recv_state     <= RX_IDLE;
            recv_divcnt    <= '0;
            recv_pattern   <= '0;
            recv_buf_data  <= '0;
            recv_buf_valid <= 1'b0;
        end else begin
            recv_divcnt <= recv_divcnt + 32'd1;
            if (reg_dat_re)
                recv_buf_valid <= 1'b0;
            unique case (recv_state)
                RX_IDLE: begin
                    if (!ser_rx)
                        recv_state <= RX_START;
                    recv_divcnt <= '0;
                end
                // half a bit period lands the data samples mid-bit
                RX_START: begin
                    if ({recv_divcnt, 1'b0} > {1'b0, cfg_divider}) begin
                        recv_state  <= RX_DATA0;
                        recv_divcnt <= '0;
                    end
                end
                RX_DATA0, RX_DATA1, RX_DATA2, RX_DATA3,
                RX_DATA4, RX_DATA5, RX_DATA6, RX_DATA7: begin
                    if (recv_divcnt > cfg_divider) begin
                        recv_pattern <= {ser_rx, recv_pattern[7:1]};
                        recv_state   <= rx_state_t'(recv_state + 4'd1);
                        recv_divcnt  <= '0;
                    end
                end
                RX_STOP: begin
                    if (recv_divcnt > cfg_divider) begin
                        recv_buf_data  <= recv_pattern;
                        recv_buf_valid <= 1'b1;
                        recv_state     <= RX_IDLE;
                    end
                end
                default: recv_state <= RX_IDLE;
            endcase
        end
    end

    // a dummy load in the same cycle as a divider write already runs
    // at the new rate, so the clear takes precedence
    always_ff @(posedge clk) begin
        if (!resetn) begin
            send_pattern <= '1;
            send_bitcnt  <= '0;
            send_divcnt  <= '0;
            send_dummy   <= 1'b1;
        end else begin
            send_divcnt <= send_divcnt + 32'd1;
            if (|reg_div_we)
                send_dummy <= 1'b1;
            if (send_dummy && send_bitcnt == 4'd0) begin
                send_pattern <= '1;
                send_bitcnt  <= TX_DUMMY_BITS;
                send_divcnt  <= '0;
                send_dummy   <= 1'b0;
            end else if (reg_dat_we && send_bitcnt == 4'd0) begin
                send_pattern <= {1'b1, reg_dat_di[7:0], 1'b0};
                send_bitcnt  <= TX_FRAME_BITS;
                send_divcnt  <= '0;
            end else if (send_divcnt > cfg_divider && send_bitcnt != 4'd0) begin
                send_pattern <= {1'b1, send_pattern[9:1]};
                send_bitcnt  <= send_bitcnt - 4'd1;
                send_divcnt  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_simpleuart.sv
// Directed self-checking bench for simpleuart: reset, idle, TX, RX,
// divider byte lanes and mid-frame reset.
module tb_simpleuart;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        ser_tx;
    logic        ser_rx = 1'b1;
    logic [3:0]  reg_div_we = 4'h0;
    logic [31:0] reg_div_di = 32'h0;
    logic [31:0] reg_div_do;
    logic        reg_dat_we = 1'b0;
    logic        reg_dat_re = 1'b0;
    logic [31:0] reg_dat_di = 32'h0;
    logic [31:0] reg_dat_do;
    logic        reg_dat_wait;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    simpleuart dut (
        .clk          (clk),
        .resetn       (resetn),
        .ser_tx       (ser_tx),
        .ser_rx       (ser_rx),
        .reg_div_we   (reg_div_we),
        .reg_div_di   (reg_div_di),
        .reg_div_do   (reg_div_do),
        .reg_dat_we   (reg_dat_we),
        .reg_dat_re   (reg_dat_re),
        .reg_dat_di   (reg_dat_di),
        .reg_dat_do   (reg_dat_do),
        .reg_dat_wait (reg_dat_wait)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // returns at the negedge right after the accepting clock edge
    task automatic send(input logic [7:0] b);
        int waited;
        waited = 0;
        reg_dat_di = {24'h0, b};
        reg_dat_we = 1'b1;
        #1;
        while (reg_dat_wait && waited < 1000) begin
            @(negedge clk);
            #1;
            waited++;
        end
        chk("tx_accept", 32'(!reg_dat_wait), 32'd1);
        @(negedge clk);
    endtask

    // 6 clocks per bit, divider 4
    task automatic rx_byte(input logic [7:0] b);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            ser_rx = f[i];
            tick(6);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] frame;
        logic       idle_ok;
        int         cnt;

        reg_dat_we = 1'b1;
        tick(2);
        chk("rst_tx", 32'(ser_tx), 32'd1);
        chk("rst_dat_do", reg_dat_do, 32'hFFFF_FFFF);
        chk("rst_div", reg_div_do, 32'd1);
        chk("rst_wait_we1", 32'(reg_dat_wait), 32'd1);
        reg_dat_we = 1'b0;
        #1;
        chk("rst_wait_we0", 32'(reg_dat_wait), 32'd0);
        tick(1);
        resetn = 1'b1;
        tick(1);

        reg_div_we = 4'hF;
        reg_div_di = 32'd4;
        tick(1);
        reg_div_we = 4'h0;
        chk("div_write", reg_div_do, 32'd4);
        idle_ok = 1'b1;
        for (int i = 0; i < 90; i++) begin
            if (ser_tx !== 1'b1)
                idle_ok = 1'b0;
            tick(1);
        end
        chk("idle_tx_high", 32'(idle_ok), 32'd1);
        chk("idle_dat_do", reg_dat_do, 32'hFFFF_FFFF);

        send(8'h55);
        frame = {1'b1, 8'h55, 1'b0};
        reg_dat_di = 32'h0000_00A5;
        for (int j = 0; j < 60; j++) begin
            chk($sformatf("tx55_bit%0d", j / 6), 32'(ser_tx), 32'(frame[j / 6]));
            chk("tx55_wait", 32'(reg_dat_wait), 32'd1);
            tick(1);
        end
        chk("tx_wait_release", 32'(reg_dat_wait), 32'd0);
        chk("tx_line_idle", 32'(ser_tx), 32'd1);
        tick(1);
        chk("tx2_start", 32'(ser_tx), 32'd0);
        reg_dat_we = 1'b0;
        tick(62);
        chk("tx2_done", 32'(ser_tx), 32'd1);

        rx_byte(8'hA3);
        chk("rx_a3", reg_dat_do, 32'h0000_00A3);
        reg_dat_re = 1'b1;
        tick(1);
        reg_dat_re = 1'b0;
        chk("rx_read_clear", reg_dat_do, 32'hFFFF_FFFF);

        rx_byte(8'h11);
        chk("rx_11", reg_dat_do, 32'h0000_0011);
        rx_byte(8'h22);
        chk("rx_overwrite_22", reg_dat_do, 32'h0000_0022);

        send(8'h00);
        reg_dat_we = 1'b0;
        tick(10);
        chk("mid_tx_low", 32'(ser_tx), 32'd0);
        resetn = 1'b0;
        tick(1);
        chk("mid_rst_tx", 32'(ser_tx), 32'd1);
        chk("mid_rst_div", reg_div_do, 32'd1);
        chk("mid_rst_dat_do", reg_dat_do, 32'hFFFF_FFFF);
        reg_dat_we = 1'b1;
        reg_dat_di = 32'h0000_005A;
        tick(1);
        resetn = 1'b1;
        cnt = 0;
        #1;
        while (reg_dat_wait && cnt < 200) begin
            cnt++;
            @(negedge clk);
            #1;
        end
        chk("dummy_stall_len", 32'(cnt), 32'd46);
        @(negedge clk);
        chk("post_rst_start", 32'(ser_tx), 32'd0);
        reg_dat_we = 1'b0;
        tick(35);

        reg_div_we = 4'b0010;
        reg_div_di = 32'h0000_1200;
        tick(1);
        reg_div_we = 4'h0;
        chk("div_byte_lane", reg_div_do, 32'h0000_1201);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
